mem_master_ctrl: RTL and testbench
==================================

// Module: mem_master_ctrl
// PURPOSE
//  Requester-side controller for the single-port synchronous memory (we/addr/din/dout).
//  Accepts word requests from the core over a valid/ready handshake and drives the memory port.
//  Returns read data and write acks over a valid/ready response channel.
//  Sits between the processor load/store path and memory; supports incrementing read bursts.
// PARAMETERS
//  ADDR_W  8   memory address width; burst addresses wrap modulo 2**ADDR_W
//  DATA_W  32  data word width
//  RD_LAT  1   memory read latency in cycles, addr-sample edge to dout valid; legal range 1..4
//  LEN_W   4   burst length field width; beats = req_len + 1, so 1..16
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  req_valid     in   1       request present
//  req_ready     out  1       controller can accept a request this cycle
//  req_we        in   1       1 = write (single beat), 0 = read (burst)
//  req_addr      in   ADDR_W  start word address
//  req_wdata     in   DATA_W  write data; ignored for reads
//  req_len       in   LEN_W   read beats minus one; ignored for writes
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       consumer accepts response
//  rsp_rdata     out  DATA_W  read data; 0 for write acks
//  rsp_is_write  out  1       response is a write ack
//  rsp_last      out  1       final beat of the transaction
//  mem_we        out  1       memory write enable
//  mem_addr      out  ADDR_W  memory address
//  mem_din       out  DATA_W  memory write data
//  mem_dout      in   DATA_W  memory read data
// BEHAVIOUR
//  Reset: all outputs are registered and are 0 while rst_n=0, including req_ready.
//  Reset is asynchronous: assertion mid-transaction drops mem_we and rsp_valid immediately.
//  Reset abandons any in-flight burst. State is IDLE from the first edge after release.
//  Memory contract: we/addr/din sampled at the rising edge. dout valid RD_LAT cycles after the addr-sample edge.
//  FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
//  - IDLE: req_ready=1. An accept occurs at edge E0 when req_valid & req_ready.
//    At E0, addr/wdata/len/we are latched into cur_addr/wdata_r/beats_left/is_wr and req_ready drops.
//    After E0, the next state is WR if req_we=1, otherwise RD_ISSUE.
//  - WR: lasts exactly 1 cycle with mem_we=1, mem_addr=cur_addr, mem_din=wdata_r; then RESP.
//    Response fields: rsp_is_write=1, rsp_rdata=0, rsp_last=1. rsp_valid is high from E1.
//  - RD_ISSUE: lasts 1 cycle with mem_addr=cur_addr and mem_we=0; then RD_WAIT.
//  - RD_WAIT: lasts RD_LAT cycles. mem_dout is captured into rsp_rdata on the last RD_WAIT edge; then RESP.
//    For the first beat, rsp_valid rises at edge E(1+RD_LAT), i.e. E2 when RD_LAT=1.
//  - RESP: rsp_valid=1. rsp_rdata, rsp_is_write, rsp_last and mem_addr hold stable until rsp_ready=1.
//    rsp_last=1 only when beats_left==0.
//    On handshake with beats_left>0: cur_addr+1 (wraps FF->00 at ADDR_W=8), beats_left-1, go to RD_ISSUE.
//    On handshake with beats_left==0: rsp_valid drops and the next state is IDLE.
//  - No request is accepted during RESP. After the last handshake, req_ready is 1 in the following cycle.
//  mem_we is high only in WR. mem_addr and mem_din otherwise hold their last driven values.
//  Reads are strictly non-pipelined: at most one memory access is outstanding.
//  Backpressure on rsp_ready stalls address issue, so no data is dropped or duplicated.
//  req_len and req_wdata are sampled only at acceptance; later changes have no effect.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0; release -> req_ready=1 after the first edge, mem_we=0.
//  2 Write addr 01 data deadbeef, then addr 02 data cafebabe.
//    Required: mem_we high exactly 1 cycle each, with the matching addr/din.
//    Each write is followed by rsp_valid with is_write=1, last=1, rdata=0.
//  3 Read addr 01 len 0 after scenario 2 -> rsp_rdata=deadbeef, last=1, rsp_valid at E2.
//    Repeat with RD_LAT=3 -> rsp_valid at E4.
//  4 Burst read addr FE len 3, memory preloaded with addr value -> mem_addr FE,FF,00,01.
//    Required: rdata 000000FE..00000001, last only on beat 4.
//  5 Hold rsp_ready=0 for 5 cycles mid-burst -> rsp_valid/rdata/mem_addr stable, no new issue.
//    After release, the next beat is correct.
//  6 Assert rst_n=0 during RD_WAIT of a burst -> outputs 0 immediately.
//    After release, a read of addr 02 returns cafebabe.

Source files
------------

// File: rtl/mem_master_ctrl.sv
// Requester-side controller for a single-port synchronous memory: single-beat writes, incrementing read bursts.
// Non-pipelined (one access outstanding); a stalled response (rsp_ready=0) holds all state and address issue.
module mem_master_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_is_write,
  output logic              rsp_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RESP} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] wdata_r;
  logic [LEN_W-1:0]  beats_left;
  logic              is_wr;
  logic [1:0]        wait_cnt;

  // The address/data registers drive the memory port directly, so they hold between accesses.
  assign mem_addr = cur_addr;
  assign mem_din  = wdata_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_addr     <= '0;
      wdata_r      <= '0;
      beats_left   <= '0;
      is_wr        <= 1'b0;
      wait_cnt     <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_is_write <= 1'b0;
      rsp_last     <= 1'b0;
      mem_we       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cur_addr   <= req_addr;
            is_wr      <= req_we;
            beats_left <= req_we ? '0 : req_len;
            req_ready  <= 1'b0;
            if (req_we) begin
              wdata_r <= req_wdata;
              mem_we  <= 1'b1;
              state   <= WR;
            end else begin
              state <= RD_ISSUE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WR: begin
          mem_we       <= 1'b0;
          rsp_valid    <= 1'b1;
          rsp_is_write <= 1'b1;
          rsp_rdata    <= '0;
          rsp_last     <= 1'b1;
          state        <= RESP;
        end
        RD_ISSUE: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            rsp_rdata    <= mem_dout;
            rsp_valid    <= 1'b1;
            rsp_is_write <= 1'b0;
            rsp_last     <= (beats_left == '0);
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (is_wr || beats_left == '0) begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              // Next beat is issued only after this one is consumed, so a stall never drops data.
              cur_addr   <= cur_addr + ADDR_W'(1);
              beats_left <= beats_left - LEN_W'(1);
              state      <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master_ctrl.sv
// Directed bench for mem_master_ctrl: transaction-level reference model plus per-cycle compare,
// with a second instance at RD_LAT=3 for the latency check.
module tb_mem_master_ctrl;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        wr;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_len = '0;
  logic        req_ready, rsp_valid, rsp_is_write, rsp_last, mem_we;
  logic [31:0] rsp_rdata, mem_din, mem_dout;
  logic [7:0]  mem_addr;

  logic        req_valid3 = 1'b0, req_we3 = 1'b0, rsp_ready3 = 1'b1;
  logic [7:0]  req_addr3 = '0;
  logic [31:0] req_wdata3 = '0;
  logic [3:0]  req_len3 = '0;
  logic        req_ready3, rsp_valid3, rsp_is_write3, rsp_last3, mem_we3;
  logic [31:0] rsp_rdata3, mem_din3, mem_dout3;
  logic [7:0]  mem_addr3;

  logic        preload_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  logic [31:0] mem [256];
  logic [31:0] mem3 [256];
  logic [31:0] p3 [3];
  logic [31:0] ref_mem [256];

  beat_t exp_rsp_q[$];
  beat_t exp_wr_q[$];
  beat_t obs_q[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] burst_tbl [4];
  logic [7:0] m_a;

  always #5 clk = ~clk;

  mem_master_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .LEN_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_is_write(rsp_is_write), .rsp_last(rsp_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_master_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3), .LEN_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .req_len(req_len3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .rsp_is_write(rsp_is_write3), .rsp_last(rsp_last3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_dout(mem_dout3)
  );

  // Memories: latency 1 for the main instance, a 3-stage output pipe for the second.
  always @(posedge clk) begin
    if (preload_en) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (preload_en) mem3[pre_addr] <= pre_data;
    else if (mem_we3) mem3[mem_addr3] <= mem_din3;
    p3[0] <= mem3[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_dout3 = p3[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each accepted request expands into its expected memory writes and responses.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_rsp_q.delete();
      exp_wr_q.delete();
    end else begin
      if (preload_en) ref_mem[pre_addr] = pre_data;
      if (req_valid && req_ready) begin
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
          exp_wr_q.push_back('{addr: req_addr, data: req_wdata, wr: 1'b1, last: 1'b1});
          exp_rsp_q.push_back('{addr: req_addr, data: 32'h0, wr: 1'b1, last: 1'b1});
        end else begin
          for (int i = 0; i <= int'(req_len); i++) begin
            m_a = req_addr + 8'(i);
            exp_rsp_q.push_back('{addr: m_a, data: ref_mem[m_a], wr: 1'b0, last: (i == int'(req_len))});
          end
        end
      end
    end
  end

  logic        stall_q = 1'b0;
  logic [31:0] st_rdata;
  logic [7:0]  st_addr;
  logic [1:0]  st_flags;
  beat_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctrl", {req_ready, rsp_valid, rsp_is_write, rsp_last, mem_we}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_addr_din", {mem_addr, mem_din}, 0);
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_rdata", rsp_rdata, st_rdata);
        chk("stall_flags", {rsp_is_write, rsp_last}, st_flags);
        chk("stall_addr", mem_addr, st_addr);
      end
      if (mem_we) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", mem_we, 0);
        else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_din", mem_din, e.data);
        end
      end
      if (rsp_valid && rsp_ready) begin
        obs_q.push_back('{addr: mem_addr, data: rsp_rdata, wr: rsp_is_write, last: rsp_last});
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_flags", {rsp_is_write, rsp_last}, {e.wr, e.last});
          chk("rsp_addr", mem_addr, e.addr);
        end
      end
      stall_q  = rsp_valid && !rsp_ready;
      st_rdata = rsp_rdata;
      st_addr  = mem_addr;
      st_flags = {rsp_is_write, rsp_last};
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    preload_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] l, input bit wait_rsp, output int lat);
    int n;
    n = 0;
    req_we = we; req_addr = a; req_wdata = d; req_len = l; req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    // Scramble the request fields: only the values at acceptance may matter.
    req_valid = 1'b0; req_wdata = 32'h0BAD0BAD; req_len = 4'hF; req_addr = 8'h77; req_we = ~we;
    lat = 0;
    if (wait_rsp) begin
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk(name, req_ready, 1);
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] r;
    logic [7:0]  ma;
    burst_tbl[0] = 8'hFE; burst_tbl[1] = 8'hFF; burst_tbl[2] = 8'h00; burst_tbl[3] = 8'h01;

    repeat (2) @(posedge clk); #1;
    chk("reset_ctrl", {req_ready, rsp_valid, mem_we, rsp_last, rsp_is_write}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", req_ready, 1);
    chk("we_after_release", mem_we, 0);

    send(1'b1, 8'h01, 32'hDEADBEEF, 4'h0, 1'b1, lat);
    chk("wr1_lat", lat, 1);
    chk("wr1_rsp", {rsp_is_write, rsp_last, rsp_rdata}, {2'b11, 32'h0});
    wait_idle("wr1_done");
    send(1'b1, 8'h02, 32'hCAFEBABE, 4'h0, 1'b1, lat);
    chk("wr2_lat", lat, 1);
    wait_idle("wr2_done");
    chk("mem_01", mem[1], 32'hDEADBEEF);
    chk("mem_02", mem[2], 32'hCAFEBABE);

    send(1'b0, 8'h01, 32'h0, 4'h0, 1'b1, lat);
    chk("rd1_lat", lat, 2);
    chk("rd1_data", rsp_rdata, 32'hDEADBEEF);
    chk("rd1_last", rsp_last, 1);
    wait_idle("rd1_done");

    for (int i = 0; i < 4; i++) preload(burst_tbl[i], {24'h0, burst_tbl[i]});
    obs_q.delete();
    send(1'b0, 8'hFE, 32'h0, 4'h3, 1'b1, lat);
    chk("burst_lat", lat, 2);
    wait_idle("burst_done");
    chk("burst_beats", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk("burst_data", obs_q[i].data, {24'h0, burst_tbl[i]});
      chk("burst_addr", obs_q[i].addr, burst_tbl[i]);
      chk("burst_last", obs_q[i].last, (i == 3));
    end

    for (int i = 0; i < 3; i++) preload(8'h10 + 8'(i), 32'h100 + 32'(i));
    obs_q.delete();
    send(1'b0, 8'h10, 32'h0, 4'h2, 1'b1, lat);
    rsp_ready = 1'b0;
    r = rsp_rdata; ma = mem_addr;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, r);
      chk("hold_addr", mem_addr, ma);
      chk("hold_we", mem_we, 0);
    end
    rsp_ready = 1'b1;
    wait_idle("stall_done");
    chk("stall_beats", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("stall_beat0", obs_q[0].data, 32'h100);
      chk("stall_beat1", obs_q[1].data, 32'h101);
      chk("stall_beat2", {obs_q[2].addr, obs_q[2].data, obs_q[2].last}, {8'h12, 32'h102, 1'b1});
    end

    send(1'b0, 8'hFE, 32'h0, 4'h3, 1'b0, lat);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {req_ready, rsp_valid, mem_we}, 0);
    chk("async_rst_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst2", req_ready, 1);
    send(1'b0, 8'h02, 32'h0, 4'h0, 1'b1, lat);
    chk("rd2_lat", lat, 2);
    chk("rd2_data", rsp_rdata, 32'hCAFEBABE);
    wait_idle("rd2_done");

    preload(8'h01, 32'hDEADBEEF);
    req_we3 = 1'b0; req_addr3 = 8'h01; req_len3 = 4'h0; req_valid3 = 1'b1;
    n = 0;
    while (!req_ready3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("lat3_ready", req_ready3, 1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("lat3_lat", lat, 4);
    chk("lat3_data", rsp_rdata3, 32'hDEADBEEF);
    chk("lat3_last", rsp_last3, 1);
    repeat (3) @(posedge clk); #1;

    chk("rsp_queue_empty", exp_rsp_q.size(), 0);
    chk("wr_queue_empty", exp_wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
